fpu_fx_collect: RTL and testbench
=================================

FPU_FX_COLLECT -- requirements
Module: fpu_fx_collect

Interface
REQ-001 SHALL have parameter LANES, default 6: number of FPU issue lanes, 1..8.
REQ-002 SHALL have parameter FLAG_W, default 11: width of the per-lane raise-flag vector.
REQ-003 SHALL have parameter TAG_W, default 9: width of the retire tag.
REQ-004 SHALL have port clk, input, 1: the only clock.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port lane_en, input, LANES: lane i produces a result this cycle.
REQ-007 SHALL have port lane_raise, input, LANES*FLAG_W: raised flags, lane i at [i*FLAG_W +: FLAG_W].
REQ-008 SHALL have port lane_tag, input, LANES*TAG_W: retire tag, lane i at [i*TAG_W +: TAG_W].
REQ-009 SHALL have port trap_mask, input, FLAG_W: flag bits that cause a trap.
REQ-010 SHALL have port clr_en, input, 1: strobe that clears sticky flags.
REQ-011 SHALL have port clr_mask, input, FLAG_W: sticky bits to clear on clr_en.
REQ-012 SHALL have port flush, input, 1: pipeline flush.
REQ-013 SHALL have port sticky, output, FLAG_W: accumulated sticky flags.
REQ-014 SHALL have port trap_valid, output, 1: trap pending.
REQ-015 SHALL have port trap_tag, output, TAG_W: tag of the trapping lane.
REQ-016 SHALL have port trap_flags, output, FLAG_W: masked flags of the trapping lane.
REQ-017 SHALL have port trap_ack, input, 1: consumer accepts the pending trap.
REQ-018 SHALL have port drop_cnt, output, 8: count of trap candidates lost while a trap was pending.

Function
REQ-019 SHALL register lane_en, lane_raise and lane_tag into stage S1 each cycle; S1 entries are valid only where lane_en was set.
REQ-020 SHALL OR the raise flags of all valid S1 lanes into sticky on the next clock edge, so sticky reflects a raise 2 cycles after input.
REQ-021 SHALL compute sticky as (sticky & ~(clr_en ? clr_mask : 0)) | new_raise; when a set and a clear hit the same bit in the same cycle, the set wins.
REQ-022 SHALL treat a valid S1 lane with (raise & trap_mask) nonzero as a trap candidate; the lowest-index candidate wins.
REQ-023 SHALL implement FSM IDLE/PEND: IDLE plus a candidate -> PEND, latching trap_tag and trap_flags = raise & trap_mask of the winning lane.
REQ-024 SHALL drive trap_valid high exactly while in PEND; trap_tag and trap_flags SHALL hold stable in PEND.
REQ-025 SHALL go PEND -> IDLE on trap_ack; a candidate arriving in the ack cycle SHALL be dropped, not captured.
REQ-026 SHALL, on flush, invalidate all S1 entries (no sticky update, no candidate) and force IDLE next cycle.
REQ-027 SHALL not clear sticky on flush.
REQ-028 SHALL ignore trap_ack while in IDLE.
REQ-029 SHALL increment drop_cnt by 1 per cycle in which one or more candidates are lost (PEND, or the ack cycle), saturating at 255.

Reset
REQ-030 SHALL, on rst, asynchronously clear S1 valids, sticky, trap_tag, trap_flags and drop_cnt, set state to IDLE, and drive trap_valid 0.
REQ-031 SHALL, when rst asserts in PEND, abandon the pending trap and not report it after reset.

Configuration
REQ-032 SHALL implement drop_cnt logic only when FPU_FX_DROP_CNT_EN is defined.
REQ-033 SHALL, without FPU_FX_DROP_CNT_EN, tie drop_cnt to 0 and still discard lost candidates.

Structure
REQ-034 SHALL place the FSM state enum, the FLAG_W default and the flag bit indices (invalid, divzero, overflow, underflow, inexact, denormal, ...) in shared package fpu_fx_pkg.
REQ-035 SHALL implement lowest-index candidate selection in one sub-module, fpu_fx_prio, which is parametrised on LANES and returns a one-hot select and a found bit.

Verification
REQ-036 SHALL check: LANES=6, lane 2 raise=11'h004 with trap_mask=0 -> sticky=11'h004 two cycles later, trap_valid stays 0.
REQ-037 SHALL check: lanes 1 and 4 both raise 11'h001 in the same cycle with trap_mask=11'h001 -> trap_valid=1 with trap_tag of lane 1, held until trap_ack.
REQ-038 SHALL check: in PEND, 3 further candidate cycles -> drop_cnt=3, trap_tag unchanged; after 300 such cycles drop_cnt=255.
REQ-039 SHALL check: clr_en with clr_mask=11'h7FF in the same cycle as a new 11'h010 raise -> sticky=11'h010.
REQ-040 SHALL check: flush in the cycle after lane_en with a trapping raise -> no sticky change and trap_valid 0; flush in PEND -> trap_valid 0 next cycle.
REQ-041 SHALL check: rst asserted mid-PEND -> all outputs 0 immediately, with no trap after rst releases.

Source files
------------

// File: rtl/fpu_fx_pkg.sv
// fpu_fx_pkg: shared definitions for the FPU exception-flag collector.
//   - fx_state_t : trap FSM states (idle / trap pending)
//   - FX_FLAG_W  : default width of a per-lane raise-flag vector
//   - FX_*       : bit positions of the individual exception flags
package fpu_fx_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } fx_state_t;

  localparam int unsigned FX_FLAG_W = 11;

  localparam int unsigned FX_INVALID   = 0;
  localparam int unsigned FX_DIVZERO   = 1;
  localparam int unsigned FX_OVERFLOW  = 2;
  localparam int unsigned FX_UNDERFLOW = 3;
  localparam int unsigned FX_INEXACT   = 4;
  localparam int unsigned FX_DENORMAL  = 5;
  localparam int unsigned FX_STK_UNDER = 6;
  localparam int unsigned FX_STK_OVER  = 7;
  localparam int unsigned FX_SNAN      = 8;
  localparam int unsigned FX_QNAN_IN   = 9;
  localparam int unsigned FX_CANCEL    = 10;

endpackage

// File: rtl/fpu_fx_prio.sv
// fpu_fx_prio: lowest-index priority select.
//   req   [LANES] : request vector
//   sel   [LANES] : one-hot select of the lowest set request (zero if none)
//   found         : at least one request is set
module fpu_fx_prio #(
  parameter int unsigned LANES = 6
) (
  input  logic [LANES-1:0] req,
  output logic [LANES-1:0] sel,
  output logic             found
);

  // req & -req isolates the least significant set bit.
  assign sel   = req & (~req + LANES'(1));
  assign found = |req;

endmodule

// File: rtl/fpu_fx_collect.sv
// fpu_fx_collect: gathers per-lane FPU exception flags into a sticky
// register and reports the first trapping lane through a pending-trap
// handshake.
//   clk, rst (async, active-high)
//   lane_en/lane_raise/lane_tag : per-lane results, registered into S1
//   trap_mask                   : flags that make a valid S1 lane trap
//   clr_en/clr_mask             : sticky clear strobe and bit mask
//   flush                       : kills current S1 entries, forces idle
//   sticky                      : accumulated raised flags
//   trap_valid/tag/flags        : pending trap, held until trap_ack
//   drop_cnt                    : saturating count of cycles with lost
//                                 trap candidates
// Build option: define FPU_FX_DROP_CNT_EN to implement drop_cnt;
// otherwise it is tied to zero (lost candidates are still discarded).
module fpu_fx_collect
  import fpu_fx_pkg::*;
#(
  parameter int unsigned LANES  = 6,
  parameter int unsigned FLAG_W = FX_FLAG_W,
  parameter int unsigned TAG_W  = 9
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LANES-1:0]          lane_en,
  input  logic [LANES*FLAG_W-1:0]   lane_raise,
  input  logic [LANES*TAG_W-1:0]    lane_tag,
  input  logic [FLAG_W-1:0]         trap_mask,
  input  logic                      clr_en,
  input  logic [FLAG_W-1:0]         clr_mask,
  input  logic                      flush,
  output logic [FLAG_W-1:0]         sticky,
  output logic                      trap_valid,
  output logic [TAG_W-1:0]          trap_tag,
  output logic [FLAG_W-1:0]         trap_flags,
  input  logic                      trap_ack,
  output logic [7:0]                drop_cnt
);

  fx_state_t                state;
  logic [LANES-1:0]         s1_valid;
  logic [LANES*FLAG_W-1:0]  s1_raise;
  logic [LANES*TAG_W-1:0]   s1_tag;

  logic [LANES-1:0]         eff_valid;
  logic [LANES-1:0]         cand;
  logic [LANES-1:0]         sel;
  logic                     found;
  logic [FLAG_W-1:0]        new_raise;
  logic [TAG_W-1:0]         win_tag;
  logic [FLAG_W-1:0]        win_flags;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) s1_valid <= '0;
    else     s1_valid <= lane_en;
  end

  always_ff @(posedge clk) begin
    s1_raise <= lane_raise;
    s1_tag   <= lane_tag;
  end

  // A flush kills whatever currently sits in S1.
  always_comb begin
    eff_valid = flush ? '0 : s1_valid;
    new_raise = '0;
    cand      = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (eff_valid[i]) begin
        new_raise = new_raise | s1_raise[i*FLAG_W +: FLAG_W];
        cand[i]   = |(s1_raise[i*FLAG_W +: FLAG_W] & trap_mask);
      end
    end
  end

  fpu_fx_prio #(.LANES(LANES)) u_prio (
    .req   (cand),
    .sel   (sel),
    .found (found)
  );

  // One-hot select turns the winner mux into a plain OR reduction.
  always_comb begin
    win_tag   = '0;
    win_flags = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (sel[i]) begin
        win_tag   = win_tag   | s1_tag[i*TAG_W +: TAG_W];
        win_flags = win_flags | (s1_raise[i*FLAG_W +: FLAG_W] & trap_mask);
      end
    end
  end

  // Set wins over clear on the same bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sticky <= '0;
    else     sticky <= (sticky & ~(clr_en ? clr_mask : '0)) | new_raise;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      trap_valid <= 1'b0;
      trap_tag   <= '0;
      trap_flags <= '0;
    end else if (flush) begin
      state      <= ST_IDLE;
      trap_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            state      <= ST_PEND;
            trap_valid <= 1'b1;
            trap_tag   <= win_tag;
            trap_flags <= win_flags;
          end
        end
        ST_PEND: begin
          if (trap_ack) begin
            state      <= ST_IDLE;
            trap_valid <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          trap_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FPU_FX_DROP_CNT_EN
  logic [7:0] drop_q;
  logic       lost;

  // Candidates are already gated by flush, so a flush cycle never counts.
  assign lost = found && (state == ST_PEND);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          drop_q <= '0;
    else if (lost && (drop_q != '1))  drop_q <= drop_q + 8'd1;
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_fpu_fx_collect.sv
module tb_fpu_fx_collect;
  localparam int unsigned LANES  = 6;
  localparam int unsigned FLAG_W = 11;
  localparam int unsigned TAG_W  = 9;
`ifdef FPU_FX_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst;
  logic [LANES-1:0]         lane_en;
  logic [LANES*FLAG_W-1:0]  lane_raise;
  logic [LANES*TAG_W-1:0]   lane_tag;
  logic [FLAG_W-1:0]        trap_mask;
  logic                     clr_en;
  logic [FLAG_W-1:0]        clr_mask;
  logic                     flush;
  logic [FLAG_W-1:0]        sticky;
  logic                     trap_valid;
  logic [TAG_W-1:0]         trap_tag;
  logic [FLAG_W-1:0]        trap_flags;
  logic                     trap_ack;
  logic [7:0]               drop_cnt;

  fpu_fx_collect #(.LANES(LANES), .FLAG_W(FLAG_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .lane_en(lane_en), .lane_raise(lane_raise),
    .lane_tag(lane_tag), .trap_mask(trap_mask), .clr_en(clr_en),
    .clr_mask(clr_mask), .flush(flush), .sticky(sticky),
    .trap_valid(trap_valid), .trap_tag(trap_tag), .trap_flags(trap_flags),
    .trap_ack(trap_ack), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FLAG_W-1:0] sticky;
    logic              tv;
    logic [TAG_W-1:0]  tag;
    logic [FLAG_W-1:0] flags;
    logic [7:0]        drop;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: the group issued last cycle is the one judged now.
  logic [FLAG_W-1:0] m_sticky;
  bit                m_pend;
  logic [TAG_W-1:0]  m_tag;
  logic [FLAG_W-1:0] m_flags;
  int                m_drop;
  bit                m_en[LANES];
  logic [FLAG_W-1:0] m_raise[LANES];
  logic [TAG_W-1:0]  m_tagv[LANES];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  task automatic model_reset();
    m_sticky = '0; m_pend = 0; m_tag = '0; m_flags = '0; m_drop = 0;
    for (int i = 0; i < LANES; i++) begin
      m_en[i] = 0; m_raise[i] = '0; m_tagv[i] = '0;
    end
  endtask

  task automatic model_step(input logic [LANES-1:0] en, input logic [LANES*FLAG_W-1:0] rf,
                            input logic [LANES*TAG_W-1:0] tf, input logic [FLAG_W-1:0] mk,
                            input logic ce, input logic [FLAG_W-1:0] cm,
                            input logic fl, input logic ak);
    logic [FLAG_W-1:0] raises;
    int first;
    bit lost;
    exp_t e;
    raises = '0; first = -1; lost = 0;
    if (!fl) begin
      for (int i = 0; i < LANES; i++) begin
        if (m_en[i]) begin
          raises = raises | m_raise[i];
          if (first < 0 && (m_raise[i] & mk) != '0) first = i;
        end
      end
    end
    m_sticky = (m_sticky & ~(ce ? cm : {FLAG_W{1'b0}})) | raises;
    if (fl) m_pend = 0;
    else if (m_pend) begin
      if (first >= 0) lost = 1;
      if (ak) m_pend = 0;
    end else if (first >= 0) begin
      m_pend  = 1;
      m_tag   = m_tagv[first];
      m_flags = m_raise[first] & mk;
    end
    if (lost && DROP_EN && m_drop < 255) m_drop++;
    for (int i = 0; i < LANES; i++) begin
      m_en[i]    = en[i];
      m_raise[i] = rf[i*FLAG_W +: FLAG_W];
      m_tagv[i]  = tf[i*TAG_W +: TAG_W];
    end
    e.sticky = m_sticky; e.tv = m_pend; e.tag = m_tag; e.flags = m_flags;
    e.drop = 8'(m_drop);
    exp_q.push_back(e);
  endtask

  // Called at a negedge: drive, predict the next edge, wait for next negedge.
  task automatic cycle(input logic [LANES-1:0] en, input logic [LANES*FLAG_W-1:0] rf,
                       input logic [LANES*TAG_W-1:0] tf, input logic [FLAG_W-1:0] mk,
                       input logic ce, input logic [FLAG_W-1:0] cm,
                       input logic fl, input logic ak);
    lane_en = en; lane_raise = rf; lane_tag = tf; trap_mask = mk;
    clr_en = ce; clr_mask = cm; flush = fl; trap_ack = ak;
    model_step(en, rf, tf, mk, ce, cm, fl, ak);
    @(negedge clk);
  endtask

  function automatic logic [LANES*TAG_W-1:0] fixed_tags();
    logic [LANES*TAG_W-1:0] t;
    for (int i = 0; i < LANES; i++) t[i*TAG_W +: TAG_W] = TAG_W'((i + 1) * 37);
    return t;
  endfunction

  function automatic logic [LANES*FLAG_W-1:0] put(input logic [LANES*FLAG_W-1:0] base,
                                                  input int lane, input logic [FLAG_W-1:0] v);
    logic [LANES*FLAG_W-1:0] r;
    r = base;
    r[lane*FLAG_W +: FLAG_W] = v;
    return r;
  endfunction

  task automatic idle(input int n, input logic [FLAG_W-1:0] mk, input logic ak);
    for (int k = 0; k < n; k++) cycle('0, '0, fixed_tags(), mk, 1'b0, '0, 1'b0, ak);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_sticky"}, 32'(sticky), 32'h0);
    chk({tag, "_trap_valid"}, 32'(trap_valid), 32'h0);
    chk({tag, "_trap_tag"}, 32'(trap_tag), 32'h0);
    chk({tag, "_trap_flags"}, 32'(trap_flags), 32'h0);
    chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'h0);
  endtask

  // Monitor: one expected snapshot per predicted clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sticky", 32'(sticky), 32'(e.sticky));
        chk("trap_valid", 32'(trap_valid), 32'(e.tv));
        chk("trap_tag", 32'(trap_tag), 32'(e.tag));
        chk("trap_flags", 32'(trap_flags), 32'(e.flags));
        chk("drop_cnt", 32'(drop_cnt), 32'(e.drop));
      end
    end
  end

  initial begin
    logic [LANES*FLAG_W-1:0] rf;
    logic [LANES*TAG_W-1:0]  tf;
    logic [LANES-1:0]        en;
    logic [FLAG_W-1:0]       mk;
    tf = fixed_tags();
    rst = 1'b1; lane_en = '0; lane_raise = '0; lane_tag = '0; trap_mask = '0;
    clr_en = 1'b0; clr_mask = '0; flush = 1'b0; trap_ack = 1'b0;
    model_reset();
    @(negedge clk);
    #1 check_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Non-trapping raise on lane 2 reaches sticky only.
    cycle(6'b000100, put('0, 2, 11'h004), tf, '0, 1'b0, '0, 1'b0, 1'b0);
    idle(3, '0, 1'b0);

    // Lanes 1 and 4 both trap; lane 1 wins and is held.
    rf = put(put('0, 1, 11'h001), 4, 11'h001);
    cycle(6'b010010, rf, tf, 11'h001, 1'b0, '0, 1'b0, 1'b0);
    idle(4, 11'h001, 1'b0);

    // Further candidates while pending are dropped.
    for (int k = 0; k < 3; k++)
      cycle(6'b000001, put('0, 0, 11'h001), tf, 11'h001, 1'b0, '0, 1'b0, 1'b0);
    idle(2, 11'h001, 1'b0);
    for (int k = 0; k < 300; k++)
      cycle(6'b001000, put('0, 3, 11'h001), tf, 11'h001, 1'b0, '0, 1'b0, 1'b0);
    // Ack with a candidate in S1: dropped, not captured.
    cycle('0, '0, tf, 11'h001, 1'b0, '0, 1'b0, 1'b1);
    idle(3, 11'h001, 1'b1);

    // Full clear in the same cycle a new raise lands: set wins.
    cycle(6'b000001, put('0, 0, 11'h010), tf, '0, 1'b0, '0, 1'b0, 1'b0);
    cycle('0, '0, tf, '0, 1'b1, 11'h7FF, 1'b0, 1'b0);
    idle(2, '0, 1'b0);

    // Flush kills a trapping raise sitting in S1.
    cycle(6'b001000, put('0, 3, 11'h002), tf, 11'h002, 1'b0, '0, 1'b0, 1'b0);
    cycle('0, '0, tf, 11'h002, 1'b0, '0, 1'b1, 1'b0);
    idle(2, 11'h002, 1'b0);
    // Flush while pending.
    cycle(6'b100000, put('0, 5, 11'h002), tf, 11'h002, 1'b0, '0, 1'b0, 1'b0);
    idle(2, 11'h002, 1'b0);
    cycle('0, '0, tf, 11'h002, 1'b0, '0, 1'b1, 1'b0);
    idle(2, 11'h002, 1'b0);

    // Reset in the middle of a pending trap.
    cycle(6'b000010, put('0, 1, 11'h008), tf, 11'h008, 1'b0, '0, 1'b0, 1'b0);
    cycle(6'b000001, put('0, 0, 11'h008), tf, 11'h008, 1'b0, '0, 1'b0, 1'b0);
    idle(1, 11'h008, 1'b0);
    rst = 1'b1;
    lane_en = '0; flush = 1'b0; trap_ack = 1'b0; clr_en = 1'b0;
    #1 check_zero_outputs("rst_mid_pend");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle(4, 11'h7FF, 1'b0);

    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      en = LANES'($urandom);
      rf = '0;
      for (int i = 0; i < LANES; i++)
        rf = put(rf, i, FLAG_W'($urandom) & FLAG_W'($urandom) & FLAG_W'($urandom));
      for (int i = 0; i < LANES; i++) tf[i*TAG_W +: TAG_W] = TAG_W'($urandom);
      mk = FLAG_W'($urandom) & FLAG_W'($urandom);
      cycle(en, rf, tf, mk, ($urandom_range(0, 9) == 0), FLAG_W'($urandom),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0));
    end
    idle(3, '0, 1'b1);

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
